// File: rtl/dac3484_link_ctrl.sv
// ---------------------------------------------------------------------------
// dac3484_link_ctrl
//
// Bring-up and run-time sequencer for the 4-channel DAC3484 LVDS data
// interface. The controller forces zero data (MUTE), then pulses SYNC, then
// waits for the first valid sample set (ALIGN) and streams data (RUN). In RUN
// it emits one FRAME pulse every FRAME_PERIOD cycles, phase-locked to the
// first streamed sample.
//
// Outputs carry one cycle of latency. The state and every output register are
// loaded together on the same edge. As a result, state_o and the data it
// describes always appear in the same cycle.
//
// Optional build macro: DAC3484_PARITY_EN
//   defined   -> parity is the even parity of the 64 registered dout bits
//   undefined -> parity is tied to 0
// ---------------------------------------------------------------------------
module dac3484_link_ctrl #(
  parameter int MUTE_CYC     = 16,
  parameter int SYNC_CYC     = 4,
  parameter int FRAME_PERIOD = 256,
  parameter int CNT_W        = 16
) (
  input  logic             clk250m,
  input  logic             rst,
  input  logic             en,
  input  logic             resync_req,
  input  logic             din_vld,
  input  logic [15:0]      din0,
  input  logic [15:0]      din1,
  input  logic [15:0]      din2,
  input  logic [15:0]      din3,
  output logic             din_rdy,
  output logic [15:0]      dout0,
  output logic [15:0]      dout1,
  output logic [15:0]      dout2,
  output logic [15:0]      dout3,
  output logic             frame,
  output logic             sync,
  output logic             parity,
  output logic             link_up,
  output logic [2:0]       state_o,
  output logic [CNT_W-1:0] underflow_cnt
);

  typedef enum logic [2:0] {
    S_IDLE  = 3'd0,
    S_MUTE  = 3'd1,
    S_SYNC  = 3'd2,
    S_ALIGN = 3'd3,
    S_RUN   = 3'd4
  } state_e;

  localparam logic [CNT_W-1:0] CNT_ONE    = CNT_W'(1);
  localparam logic [CNT_W-1:0] MUTE_LAST  = CNT_W'(MUTE_CYC - 1);
  localparam logic [CNT_W-1:0] SYNC_LAST  = CNT_W'(SYNC_CYC - 1);
  localparam logic [CNT_W-1:0] FRAME_LAST = CNT_W'(FRAME_PERIOD - 1);

  // Registered state and outputs
  state_e           state_q, state_d;
  logic [CNT_W-1:0] cnt_q, cnt_d;     // MUTE / SYNC dwell counter
  logic [CNT_W-1:0] fcnt_q, fcnt_d;   // FRAME phase counter
  logic [CNT_W-1:0] uf_q, uf_d;       // saturating underflow count
  logic [15:0]      dout0_q, dout0_d;
  logic [15:0]      dout1_q, dout1_d;
  logic [15:0]      dout2_q, dout2_d;
  logic [15:0]      dout3_q, dout3_d;
  logic             frame_q, frame_d;
  logic             sync_q, sync_d;
  logic             parity_q, parity_d;
  logic             din_rdy_q, din_rdy_d;
  logic             link_up_q, link_up_d;

  // Next-state and next-output decode. The priority is en=0, then resync, then normal progression.
  always_comb begin
    // NOTE: every signal gets a default first, so no path through the
    // branches below can leave one unassigned and infer a latch.
    state_d  = state_q;
    cnt_d    = cnt_q;
    fcnt_d   = fcnt_q;
    uf_d     = uf_q;
    dout0_d  = '0;
    dout1_d  = '0;
    dout2_d  = '0;
    dout3_d  = '0;
    frame_d  = 1'b0;

    if (!en) begin
      state_d = S_IDLE;
      cnt_d   = '0;
      fcnt_d  = '0;
    end else if (resync_req &&
                 (state_q == S_SYNC || state_q == S_ALIGN || state_q == S_RUN)) begin
      // Re-run the bring-up sequence; the underflow history is kept.
      state_d = S_MUTE;
      cnt_d   = '0;
      fcnt_d  = '0;
    end else begin
      unique case (state_q)
        S_IDLE: begin
          state_d = S_MUTE;
          cnt_d   = '0;
        end

        S_MUTE: begin
          if (cnt_q == MUTE_LAST) begin
            state_d = S_SYNC;
            cnt_d   = '0;
          end else begin
            cnt_d = cnt_q + CNT_ONE;
          end
        end

        S_SYNC: begin
          if (cnt_q == SYNC_LAST) begin
            state_d = S_ALIGN;
            cnt_d   = '0;
          end else begin
            cnt_d = cnt_q + CNT_ONE;
          end
        end

        S_ALIGN: begin
          // The first valid sample defines the frame phase.
          if (din_vld) begin
            state_d = S_RUN;
            dout0_d = din0;
            dout1_d = din1;
            dout2_d = din2;
            dout3_d = din3;
            frame_d = 1'b1;
            fcnt_d  = CNT_ONE;
          end
        end

        S_RUN: begin
          if (din_vld) begin
            dout0_d = din0;
            dout1_d = din1;
            dout2_d = din2;
            dout3_d = din3;
          end else if (uf_q != '1) begin
            uf_d = uf_q + CNT_ONE;
          end
          frame_d = (fcnt_q == '0);
          fcnt_d  = (fcnt_q == FRAME_LAST) ? '0 : fcnt_q + CNT_ONE;
        end

        default: begin
          // Unused encodings behave as IDLE, and en is high on this path.
          state_d = S_MUTE;
          cnt_d   = '0;
          fcnt_d  = '0;
        end
      endcase
    end

    // These are level outputs that follow the state being entered.
    sync_d    = (state_d == S_SYNC);
    din_rdy_d = (state_d == S_ALIGN) || (state_d == S_RUN);
    link_up_d = (state_d == S_RUN);

`ifdef DAC3484_PARITY_EN
    parity_d = ^{dout0_d, dout1_d, dout2_d, dout3_d};
`else
    parity_d = 1'b0;
`endif
  end

  // State and output registers with synchronous active-high reset
  always_ff @(posedge clk250m) begin
    // NOTE: sequential state is written only with non-blocking assignments,
    // so every register samples the values from before this edge.
    if (rst) begin
      state_q   <= S_IDLE;
      cnt_q     <= '0;
      fcnt_q    <= '0;
      uf_q      <= '0;
      dout0_q   <= '0;
      dout1_q   <= '0;
      dout2_q   <= '0;
      dout3_q   <= '0;
      frame_q   <= 1'b0;
      sync_q    <= 1'b0;
      parity_q  <= 1'b0;
      din_rdy_q <= 1'b0;
      link_up_q <= 1'b0;
    end else begin
      state_q   <= state_d;
      cnt_q     <= cnt_d;
      fcnt_q    <= fcnt_d;
      uf_q      <= uf_d;
      dout0_q   <= dout0_d;
      dout1_q   <= dout1_d;
      dout2_q   <= dout2_d;
      dout3_q   <= dout3_d;
      frame_q   <= frame_d;
      sync_q    <= sync_d;
      parity_q  <= parity_d;
      din_rdy_q <= din_rdy_d;
      link_up_q <= link_up_d;
    end
  end

  assign dout0         = dout0_q;
  assign dout1         = dout1_q;
  assign dout2         = dout2_q;
  assign dout3         = dout3_q;
  assign frame         = frame_q;
  assign sync          = sync_q;
  assign parity        = parity_q;
  assign din_rdy       = din_rdy_q;
  assign link_up       = link_up_q;
  assign state_o       = state_q;
  assign underflow_cnt = uf_q;

endmodule

// File: tb/tb_dac3484_link_ctrl.sv
// ---------------------------------------------------------------------------
// tb_dac3484_link_ctrl
//
// Directed bench for dac3484_link_ctrl with MUTE_CYC=4, SYNC_CYC=2,
// FRAME_PERIOD=8 and CNT_W=4. A 4-bit CNT_W lets the bench reach underflow
// saturation.
//
// On each falling edge the driver applies inputs. It also queues the output
// set expected after the next rising edge. The monitor pops one entry per
// rising edge, 1 ns after the edge, and compares it with the DUT outputs.
// ---------------------------------------------------------------------------
module tb_dac3484_link_ctrl;

  localparam int CW = 4;

  localparam logic [2:0] ST_IDLE  = 3'd0;
  localparam logic [2:0] ST_MUTE  = 3'd1;
  localparam logic [2:0] ST_SYNC  = 3'd2;
  localparam logic [2:0] ST_ALIGN = 3'd3;
  localparam logic [2:0] ST_RUN   = 3'd4;

  typedef struct packed {
    logic [2:0]    st;
    logic [15:0]   d0;
    logic [15:0]   d1;
    logic [15:0]   d2;
    logic [15:0]   d3;
    logic          fr;
    logic          sy;
    logic          rdy;
    logic          up;
    logic          par;
    logic [CW-1:0] uf;
  } obs_t;

  logic          clk250m = 1'b0;
  logic          rst = 1'b1;
  logic          en = 1'b0;
  logic          resync_req = 1'b0;
  logic          din_vld = 1'b0;
  logic [15:0]   din0 = '0, din1 = '0, din2 = '0, din3 = '0;
  logic          din_rdy;
  logic [15:0]   dout0, dout1, dout2, dout3;
  logic          frame, sync, parity, link_up;
  logic [2:0]    state_o;
  logic [CW-1:0] underflow_cnt;

  obs_t  exp_q[$];
  string name_q[$];
  int    n_checks = 0;
  int    n_errors = 0;
  int    run_k    = 0;          // RUN edges since the ALIGN sample
  logic [CW-1:0] uf_exp = '0;   // bench-side underflow tally

  dac3484_link_ctrl #(
    .MUTE_CYC    (4),
    .SYNC_CYC    (2),
    .FRAME_PERIOD(8),
    .CNT_W       (CW)
  ) dut (
    .clk250m      (clk250m),
    .rst          (rst),
    .en           (en),
    .resync_req   (resync_req),
    .din_vld      (din_vld),
    .din0         (din0),
    .din1         (din1),
    .din2         (din2),
    .din3         (din3),
    .din_rdy      (din_rdy),
    .dout0        (dout0),
    .dout1        (dout1),
    .dout2        (dout2),
    .dout3        (dout3),
    .frame        (frame),
    .sync         (sync),
    .parity       (parity),
    .link_up      (link_up),
    .state_o      (state_o),
    .underflow_cnt(underflow_cnt)
  );

  always #5 clk250m = ~clk250m;

  function automatic obs_t mk(input logic [2:0] st,
                              input logic [15:0] a, b, c, d,
                              input logic fr, sy, rdy, up,
                              input logic [CW-1:0] uf);
    obs_t o;
    o.st  = st;
    o.d0  = a;
    o.d1  = b;
    o.d2  = c;
    o.d3  = d;
    o.fr  = fr;
    o.sy  = sy;
    o.rdy = rdy;
    o.up  = up;
`ifdef DAC3484_PARITY_EN
    o.par = ^{a, b, c, d};
`else
    o.par = 1'b0;
`endif
    o.uf  = uf;
    return o;
  endfunction

  // Apply one cycle of inputs and queue the outputs expected after the next edge.
  task automatic step(input string nm, input logic r, e, rs, v,
                      input logic [15:0] a, b, c, d, input obs_t x);
    @(negedge clk250m);
    rst        = r;
    en         = e;
    resync_req = rs;
    din_vld    = v;
    din0       = a;
    din1       = b;
    din2       = c;
    din3       = d;
    exp_q.push_back(x);
    name_q.push_back(nm);
  endtask

  task automatic check(input string nm, input obs_t got, input obs_t want);
    n_checks++;
    if (got !== want) begin
      n_errors++;
      $display("FAIL %s: got st=%0d d=%h_%h_%h_%h fr=%b sy=%b rdy=%b up=%b par=%b uf=%0d, expected st=%0d d=%h_%h_%h_%h fr=%b sy=%b rdy=%b up=%b par=%b uf=%0d",
               nm, got.st, got.d0, got.d1, got.d2, got.d3, got.fr, got.sy,
               got.rdy, got.up, got.par, got.uf,
               want.st, want.d0, want.d1, want.d2, want.d3, want.fr, want.sy,
               want.rdy, want.up, want.par, want.uf);
    end
  endtask

  // Monitor: compare the DUT output set with the queued expectation
  always @(posedge clk250m) begin : monitor
    obs_t  got;
    obs_t  want;
    string nm;
    #1;
    if (exp_q.size() > 0) begin
      want = exp_q.pop_front();
      nm   = name_q.pop_front();
      got  = '{st: state_o, d0: dout0, d1: dout1, d2: dout2, d3: dout3,
               fr: frame, sy: sync, rdy: din_rdy, up: link_up, par: parity,
               uf: underflow_cnt};
      check(nm, got, want);
    end
  end

  // Drive the sequence MUTE(4) -> SYNC(2) -> ALIGN. A resync pulse during MUTE is ignored.
  task automatic bringup(input string tag, input bit from_run);
    step({tag, "_mute0"}, 0, 1, from_run, from_run, 16'hDEAD, 16'hBEEF, 16'hCAFE, 16'hF00D,
         mk(ST_MUTE, 0, 0, 0, 0, 0, 0, 0, 0, uf_exp));
    step({tag, "_mute1"}, 0, 1, 0, 0, 0, 0, 0, 0, mk(ST_MUTE, 0, 0, 0, 0, 0, 0, 0, 0, uf_exp));
    step({tag, "_mute2_resync_ignored"}, 0, 1, 1, 0, 0, 0, 0, 0,
         mk(ST_MUTE, 0, 0, 0, 0, 0, 0, 0, 0, uf_exp));
    step({tag, "_mute3"}, 0, 1, 0, 0, 0, 0, 0, 0, mk(ST_MUTE, 0, 0, 0, 0, 0, 0, 0, 0, uf_exp));
    step({tag, "_sync0"}, 0, 1, 0, 0, 0, 0, 0, 0, mk(ST_SYNC, 0, 0, 0, 0, 0, 1, 0, 0, uf_exp));
    step({tag, "_sync1"}, 0, 1, 0, 0, 0, 0, 0, 0, mk(ST_SYNC, 0, 0, 0, 0, 0, 1, 0, 0, uf_exp));
    step({tag, "_align"}, 0, 1, 0, 0, 0, 0, 0, 0, mk(ST_ALIGN, 0, 0, 0, 0, 0, 0, 1, 0, uf_exp));
    step({tag, "_align_wait"}, 0, 1, 0, 0, 16'h5555, 0, 0, 0,
         mk(ST_ALIGN, 0, 0, 0, 0, 0, 0, 1, 0, uf_exp));
  endtask

  // The first valid sample in ALIGN produces a FRAME and starts the frame phase.
  task automatic align_sample(input string tag, input logic [15:0] a, b, c, d);
    run_k = 0;
    step({tag, "_first_sample"}, 0, 1, 0, 1, a, b, c, d,
         mk(ST_RUN, a, b, c, d, 1, 0, 1, 1, uf_exp));
  endtask

  // Run one RUN cycle. FRAME is expected on every 8th cycle after the ALIGN sample.
  task automatic run_cyc(input string nm, input logic v, input logic [15:0] a, b, c, d);
    logic fr;
    run_k++;
    fr = ((run_k % 8) == 0);
    if (!v && uf_exp != '1) uf_exp = uf_exp + 1'b1;
    if (v) step(nm, 0, 1, 0, 1, a, b, c, d, mk(ST_RUN, a, b, c, d, fr, 0, 1, 1, uf_exp));
    else   step(nm, 0, 1, 0, 0, a, b, c, d, mk(ST_RUN, 0, 0, 0, 0, fr, 0, 1, 1, uf_exp));
  endtask

  initial begin : stimulus
    logic [23:0] pat;
    pat = 24'b1011_0010_1110_0001_1001_0110;

    // Reset, then idle. A resync request in IDLE is ignored.
    step("reset0", 1, 0, 0, 0, 0, 0, 0, 0, mk(ST_IDLE, 0, 0, 0, 0, 0, 0, 0, 0, 0));
    step("reset1", 1, 1, 0, 1, 16'hFFFF, 16'hFFFF, 16'hFFFF, 16'hFFFF,
         mk(ST_IDLE, 0, 0, 0, 0, 0, 0, 0, 0, 0));
    step("idle_resync_ignored", 0, 0, 1, 0, 0, 0, 0, 0,
         mk(ST_IDLE, 0, 0, 0, 0, 0, 0, 0, 0, 0));

    // First bring-up and alignment
    bringup("bu1", 1'b0);
    align_sample("bu1", 16'h1111, 16'h2222, 16'h3333, 16'h4444);

    // RUN with a fixed valid/underflow pattern over three frame periods
    for (int i = 0; i < 24; i++) begin
      run_cyc($sformatf("run1_c%0d", i), pat[23 - i],
              16'(16'h0100 + i), 16'(16'h0A50 ^ i), 16'(i * 7), 16'hC3C3);
    end

    // Resync from RUN. The sequence repeats, and the frame phase locks to the new first sample.
    bringup("bu2", 1'b1);
    align_sample("bu2", 16'h0001, 16'h0000, 16'h0000, 16'h0000);
    run_cyc("run2_par_0003", 1'b1, 16'h0003, 16'h0000, 16'h0000, 16'h0000);
    for (int i = 0; i < 12; i++) begin
      run_cyc($sformatf("run2_under%0d", i), 1'b0, 16'h7777, 16'h8888, 0, 0);
    end
    for (int i = 0; i < 6; i++) begin
      run_cyc($sformatf("run2_tail%0d", i), 1'b1, 16'(16'h2000 + i), 0, 16'hFFFF, 16'h0F0F);
    end

    // resync_req and en=0 together in RUN go to IDLE, with no MUTE entry.
    step("resync_and_disable", 0, 0, 1, 1, 16'h1234, 16'h1234, 16'h1234, 16'h1234,
         mk(ST_IDLE, 0, 0, 0, 0, 0, 0, 0, 0, uf_exp));
    step("idle_hold", 0, 0, 0, 1, 16'h1234, 0, 0, 0,
         mk(ST_IDLE, 0, 0, 0, 0, 0, 0, 0, 0, uf_exp));

    // Bring up again, then reset in the middle of SYNC.
    step("bu3_mute0", 0, 1, 0, 0, 0, 0, 0, 0, mk(ST_MUTE, 0, 0, 0, 0, 0, 0, 0, 0, uf_exp));
    for (int i = 1; i < 4; i++) begin
      step($sformatf("bu3_mute%0d", i), 0, 1, 0, 0, 0, 0, 0, 0,
           mk(ST_MUTE, 0, 0, 0, 0, 0, 0, 0, 0, uf_exp));
    end
    step("bu3_sync0", 0, 1, 0, 0, 0, 0, 0, 0, mk(ST_SYNC, 0, 0, 0, 0, 0, 1, 0, 0, uf_exp));
    uf_exp = '0;
    step("rst_mid_sync", 1, 1, 0, 0, 0, 0, 0, 0, mk(ST_IDLE, 0, 0, 0, 0, 0, 0, 0, 0, 0));
    step("rst_hold", 1, 1, 1, 1, 16'hAAAA, 0, 0, 0, mk(ST_IDLE, 0, 0, 0, 0, 0, 0, 0, 0, 0));
    step("post_rst_mute", 0, 1, 0, 0, 0, 0, 0, 0, mk(ST_MUTE, 0, 0, 0, 0, 0, 0, 0, 0, 0));

    // Let the monitor drain the queue.
    repeat (3) @(negedge clk250m);
    n_checks++;
    if (exp_q.size() != 0) begin
      n_errors++;
      $display("FAIL queue_drain: %0d entries left, expected 0", exp_q.size());
    end
    $display("CHECKS %0d ERRORS %0d", n_checks, n_errors);
    $finish;
  end

endmodule
